// File: rtl/instruction_queue.sv
// instruction_queue: DEPTH-entry FIFO plus one registered output stage
// between fetch and decode, valid/ready on both sides, synchronous flush.
//
// Ports:
//   clock, reset (sync, active-low), flush (sync discard)
//   in_valid/in_ready/in_instr    : fetch side handshake
//   out_valid/out_ready/out_instr : decode side handshake (registered)
//   count                         : FIFO entries + out_valid
//
// Build option: define INSTR_QUEUE_BYPASS_EN to let a push into an empty
// FIFO load straight into the output stage (1-cycle latency).
module instruction_queue #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 2)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_instr,
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_instr_q, out_instr_d;

    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             stage_free;
    logic             load_head;
    logic             load_byp;
    logic             mem_we;
    logic [AW:0]      fifo_level;

    // Extra pointer bit distinguishes full from empty.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Registered state only: no out_ready -> in_ready path.
    assign in_ready   = !fifo_full;
    assign push       = in_valid && in_ready && !flush;
    assign stage_free = !out_valid_q || out_ready;
    assign load_head  = stage_free && !fifo_empty;

`ifdef INSTR_QUEUE_BYPASS_EN
    // Only when the FIFO is empty, so ordering is preserved.
    assign load_byp = stage_free && fifo_empty && push;
`else
    assign load_byp = 1'b0;
`endif

    assign mem_we = push && !load_byp;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        if (mem_we) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (load_head) begin
            rd_ptr_d    = rd_ptr_q + (AW+1)'(1);
            out_valid_d = 1'b1;
            out_instr_d = mem_q[rd_ptr_q[AW-1:0]];
        end else if (load_byp) begin
            out_valid_d = 1'b1;
            out_instr_d = in_instr;
        end else if (stage_free) begin
            // Consumed (or idle) with nothing to refill: hold the data.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (reset && mem_we) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_instr;
        end
    end

    assign fifo_level = wr_ptr_q - rd_ptr_q;
    assign count      = CNT_W'(fifo_level) + CNT_W'(out_valid_q);
    assign out_valid  = out_valid_q;
    assign out_instr  = out_instr_q;

endmodule
